conv_bram_1d_result_rd: RTL

//  Reader at the far end of the conv_bram_1d result-RAM interface: once a convolution pass finishes, it

---
 rtl/conv_1d_pkg.sv | 21 ++
 rtl/conv_bram_1d_rd_fifo.sv | 75 +++++++
 rtl/conv_bram_1d_result_rd.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/conv_1d_pkg.sv
// Shared definitions for the conv_bram_1d family: reader FSM states and
// the geometry helpers that derive the result width and RAM address width.
package conv_1d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Number of output positions produced by one convolution pass.
  function automatic int calc_result_w(input int img_w, input int filter_l, input int stride_w);
    return (img_w - filter_l) / stride_w + 1;
  endfunction

  // Address width of a result bank; never narrower than one bit.
  function automatic int calc_addr_w(input int result_w);
    return (result_w > 1) ? $clog2(result_w) : 1;
  endfunction

endpackage

// File: rtl/conv_bram_1d_rd_fifo.sv
// Two-entry FIFO with a registered head. Entry 0 (head) drives the output
// directly; entry 1 (tail) only fills while the head is waiting.
module conv_bram_1d_rd_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [1:0]       o_occ,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_head_val
);

  logic [WIDTH-1:0] r_head_data;
  logic             r_head_val;
  logic [WIDTH-1:0] r_tail_data;
  logic             r_tail_val;

  logic [WIDTH-1:0] w_head_data_next;
  logic             w_head_val_next;
  logic [WIDTH-1:0] w_tail_data_next;
  logic             w_tail_val_next;

  // Next-state of both entries; a pop promotes the tail, a push fills the first free slot.
  always_comb begin
    w_head_data_next = r_head_data;
    w_head_val_next  = r_head_val;
    w_tail_data_next = r_tail_data;
    w_tail_val_next  = r_tail_val;
    if (i_pop && r_head_val) begin
      if (r_tail_val) begin
        w_head_data_next = r_tail_data;
        w_tail_val_next  = i_push;
        if (i_push) begin
          w_tail_data_next = i_push_data;
        end
      end else begin
        w_head_val_next = i_push;
        if (i_push) begin
          w_head_data_next = i_push_data;
        end
      end
    end else if (i_push) begin
      if (!r_head_val) begin
        w_head_val_next  = 1'b1;
        w_head_data_next = i_push_data;
      end else begin
        w_tail_val_next  = 1'b1;
        w_tail_data_next = i_push_data;
      end
    end
  end

  // Entry registers; reset empties the FIFO and zeroes the head so out_data reads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head_data <= '0;
      r_head_val  <= 1'b0;
      r_tail_data <= '0;
      r_tail_val  <= 1'b0;
    end else begin
      r_head_data <= w_head_data_next;
      r_head_val  <= w_head_val_next;
      r_tail_data <= w_tail_data_next;
      r_tail_val  <= w_tail_val_next;
    end
  end

  assign o_occ       = {1'b0, r_head_val} + {1'b0, r_tail_val};
  assign o_head_data = r_head_data;
  assign o_head_val  = r_head_val;

endmodule

// File: rtl/conv_bram_1d_result_rd.sv
// Result-RAM reader: after a start request, sweeps all result banks from
// address 0 to RESULT_W-1 and streams one column (all channels) per beat.
// Reads are only issued when the 2-entry output FIFO is guaranteed room,
// so read data is never dropped under backpressure.
module conv_bram_1d_result_rd
  import conv_1d_pkg::*;
#(
  parameter  int DATA_WIDTH            = 8,
  parameter  int IMG_W                 = 32,
  parameter  int FILTER_L              = 3,
  parameter  int RESULT_D              = 4,
  parameter  int STRIDE_W              = 1,
  localparam int RESULT_W              = calc_result_w(IMG_W, FILTER_L, STRIDE_W),
  localparam int RESULT_RAM_ADDR_WIDTH = calc_addr_w(RESULT_W)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start_val,
  output logic                                      start_rdy,
  output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_rdaddr,
  input  logic [DATA_WIDTH*RESULT_D-1:0]            result_rddata,
  output logic [DATA_WIDTH*RESULT_D-1:0]            out_data,
  output logic                                      out_val,
  input  logic                                      out_rdy,
  output logic                                      out_last,
  output logic                                      done
);

  localparam int AW = RESULT_RAM_ADDR_WIDTH;
  localparam int CW = DATA_WIDTH * RESULT_D;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RESULT_W - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_rdaddr;
  logic          r_inflight;
  logic          r_inflight_last;
  logic          r_done;

  logic          w_issue;
  logic          w_start;
  logic          w_credit;
  logic          w_pop;
  logic [1:0]    w_occ;
  logic [CW:0]   w_head_data;
  logic          w_head_val;
  logic          w_out_last;
  logic [AW-1:0] w_rdaddr;

  assign w_pop      = w_head_val & out_rdy;
  assign w_out_last = w_head_val & w_head_data[CW];

  // Issue only if the FIFO entries plus the read already in flight, minus
  // this cycle's pop, leave at least one free slot.
  assign w_credit = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  // Next-state and read-issue decode.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_val) begin
          w_start      = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_cnt == LAST_ADDR) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_pop && w_out_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Address counter and the held copy of the last issued address (0 whenever idle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_rdaddr <= '0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_issue) begin
        r_cnt <= (r_cnt == LAST_ADDR) ? '0 : r_cnt + 1'b1;
      end
      if (w_state_next == IDLE) begin
        r_rdaddr <= '0;
      end else if (w_issue) begin
        r_rdaddr <= r_cnt;
      end
    end
  end

  // Track the one-cycle RAM latency: which cycle carries valid read data and whether it is the last column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_cnt == LAST_ADDR);
    end
  end

  // Done pulses the cycle after the final beat is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN) && w_pop && w_out_last;
    end
  end

  conv_bram_1d_rd_fifo #(
    .WIDTH (CW + 1)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_push_data ({r_inflight_last, result_rddata}),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head_data (w_head_data),
    .o_head_val  (w_head_val)
  );

  assign w_rdaddr = w_issue ? r_cnt : r_rdaddr;

  generate
    for (genvar gi = 0; gi < RESULT_D; gi++) begin : g_addr_rep
      assign result_rdaddr[gi*AW +: AW] = w_rdaddr;
    end
  endgenerate

  assign start_rdy = (r_state == IDLE);
  assign out_data  = w_head_data[CW-1:0];
  assign out_val   = w_head_val;
  assign out_last  = w_out_last;
  assign done      = r_done;

endmodule
